// File: rtl/seg_bus_pkg.sv
// Shared constants and types for the multiplexed four-digit display bus.
package seg_bus_pkg;

  localparam logic [3:0] AN_D0    = 4'b1110;
  localparam logic [3:0] AN_D1    = 4'b1101;
  localparam logic [3:0] AN_D2    = 4'b1011;
  localparam logic [3:0] AN_D3    = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b0000;
  localparam logic [3:0] AN_IDLE  = 4'b1111;

  localparam int IDLE_MAX_DEFAULT = 8;

  typedef enum logic {
    HUNT,
    COLLECT
  } rx_state_t;

endpackage

// File: rtl/seg_bus_receiver_if.sv
// Display bus plus receiver status; master drives the scan, slave is the receiver.
interface seg_bus_receiver_if;

  logic [3:0]  an_in;
  logic [3:0]  digit_in;
  logic [15:0] value;
  logic        frame_valid;
  logic        locked;
  logic        err;
  logic [7:0]  err_count;

  modport master (
    output an_in, digit_in,
    input  value, frame_valid, locked, err, err_count
  );

  modport slave (
    input  an_in, digit_in,
    output value, frame_valid, locked, err, err_count
  );

endinterface

// File: rtl/seg_an_decoder.sv
// Classifies an active-low digit-enable pattern into strobe/index, blank, idle or illegal.
module seg_an_decoder
  import seg_bus_pkg::*;
(
  input  logic [3:0] an_in,
  output logic       strobe,
  output logic [1:0] idx,
  output logic       blank,
  output logic       idle,
  output logic       illegal
);

  always_comb begin
    strobe  = 1'b0;
    idx     = 2'd0;
    blank   = 1'b0;
    idle    = 1'b0;
    illegal = 1'b0;
    case (an_in)
      AN_D0:    begin strobe = 1'b1; idx = 2'd0; end
      AN_D1:    begin strobe = 1'b1; idx = 2'd1; end
      AN_D2:    begin strobe = 1'b1; idx = 2'd2; end
      AN_D3:    begin strobe = 1'b1; idx = 2'd3; end
      AN_BLANK: blank   = 1'b1;
      AN_IDLE:  idle    = 1'b1;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_bus_receiver.sv
// Reassembles the scanned 16-bit display value and tracks digit-sequence lock.
// Optional saturating error counter: define SEG_RX_ERRCNT_EN.
module seg_bus_receiver
  import seg_bus_pkg::*;
#(
  parameter int IDLE_MAX = IDLE_MAX_DEFAULT
) (
  input  logic              kHzclk,
  input  logic              reset,
  seg_bus_receiver_if.slave bus
);

  localparam int IW = $clog2(IDLE_MAX + 1);

  logic          strobe, blank, idle, illegal;
  logic [1:0]    idx;

  rx_state_t     state_q, state_d;
  logic [1:0]    expect_q, expect_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   value_q, value_d;
  logic          fv_q, fv_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [IW-1:0] idle_q, idle_d;

  seg_an_decoder u_dec (
    .an_in   (bus.an_in),
    .strobe  (strobe),
    .idx     (idx),
    .blank   (blank),
    .idle    (idle),
    .illegal (illegal)
  );

  always_ff @(posedge kHzclk or posedge reset) begin
    if (reset) begin
      state_q  <= HUNT;
      expect_q <= 2'd0;
      shadow_q <= 16'h0000;
      value_q  <= 16'h0000;
      fv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      expect_q <= expect_d;
      shadow_q <= shadow_d;
      value_q  <= value_d;
      fv_q     <= fv_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      idle_q   <= idle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    shadow_d = shadow_q;
    value_d  = value_q;
    fv_d     = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;
    idle_d   = '0;
    case (state_q)
      HUNT: begin
        if (strobe && idx == 2'd0) begin
          shadow_d[3:0] = bus.digit_in;
          expect_d      = 2'd1;
          state_d       = COLLECT;
        end
      end
      COLLECT: begin
        if (strobe && idx == expect_q) begin
          shadow_d[{expect_q, 2'b00} +: 4] = bus.digit_in;
          expect_d = expect_q + 2'd1;
          if (expect_q == 2'd3) begin
            value_d  = {bus.digit_in, shadow_q[11:0]};
            fv_d     = 1'b1;
            locked_d = 1'b1;
          end
        end else if (strobe || illegal) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          shadow_d = 16'h0000;
          // An out-of-order digit 0 is the start of a new frame, so keep it.
          if (strobe && idx == 2'd0) begin
            shadow_d[3:0] = bus.digit_in;
            expect_d      = 2'd1;
          end else begin
            state_d  = HUNT;
            expect_d = 2'd0;
          end
        end else if (blank) begin
          state_d  = HUNT;
          expect_d = 2'd0;
          locked_d = 1'b0;
        end else if (idle_q == IW'(IDLE_MAX - 1)) begin
          state_d  = HUNT;
          expect_d = 2'd0;
          locked_d = 1'b0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      default: begin
        state_d  = HUNT;
        expect_d = 2'd0;
      end
    endcase
  end

  assign bus.value       = value_q;
  assign bus.frame_valid = fv_q;
  assign bus.locked      = locked_q;
  assign bus.err         = err_q;

`ifdef SEG_RX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge kHzclk or posedge reset) begin
    if (reset)
      err_cnt_q <= 8'h00;
    else if (err_d && err_cnt_q != 8'hFF)
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seg_bus_receiver.sv
// Directed bench for seg_bus_receiver with a digit-list reference model checked every cycle.
module tb_seg_bus_receiver;

  localparam int IDLE_MAX = 8;

  logic kHzclk = 1'b0;
  logic reset  = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  seg_bus_receiver_if bus ();

  seg_bus_receiver #(.IDLE_MAX(IDLE_MAX)) dut (
    .kHzclk (kHzclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 kHzclk = ~kHzclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: number of in-order digits held (-1 = hunting) and the digits themselves.
  int         m_pos;
  logic [3:0] m_dig [4];
  logic [15:0] m_value;
  logic       m_fv, m_lock, m_err;
  int         m_idle;
  int         m_errcnt;

  function automatic int classify(input logic [3:0] an);
    int zeros = 0;
    int where = 0;
    for (int i = 0; i < 4; i++)
      if (an[i] == 1'b0) begin zeros++; where = i; end
    if (zeros == 1) return where;
    if (zeros == 4) return -2;
    if (zeros == 0) return -3;
    return -4;
  endfunction

  always @(posedge kHzclk or posedge reset) begin
    if (reset) begin
      m_pos = -1; m_value = 16'h0; m_fv = 0; m_lock = 0; m_err = 0; m_idle = 0; m_errcnt = 0;
    end else begin
      int d;
      d    = classify(bus.an_in);
      m_fv = 0;
      m_err = 0;
      if (m_pos < 0) begin
        m_idle = 0;
        if (d == 0) begin m_dig[0] = bus.digit_in; m_pos = 1; end
      end else if (d >= 0) begin
        m_idle = 0;
        if (d == m_pos) begin
          m_dig[d] = bus.digit_in;
          if (d == 3) begin
            m_value = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
            m_fv = 1; m_lock = 1; m_pos = 0;
          end else m_pos = m_pos + 1;
        end else begin
          m_err = 1; m_lock = 0;
          if (d == 0) begin m_dig[0] = bus.digit_in; m_pos = 1; end
          else m_pos = -1;
        end
      end else if (d == -4) begin
        m_err = 1; m_lock = 0; m_pos = -1; m_idle = 0;
      end else if (d == -2) begin
        m_lock = 0; m_pos = -1; m_idle = 0;
      end else begin
        m_idle = m_idle + 1;
        if (m_idle == IDLE_MAX) begin m_lock = 0; m_pos = -1; m_idle = 0; end
      end
`ifdef SEG_RX_ERRCNT_EN
      if (m_err && m_errcnt < 255) m_errcnt = m_errcnt + 1;
`endif
    end
  end

  always @(negedge kHzclk) begin
    if (!reset) begin
      chk("model_value",  32'(bus.value),       32'(m_value));
      chk("model_fv",     32'(bus.frame_valid), 32'(m_fv));
      chk("model_locked", 32'(bus.locked),      32'(m_lock));
      chk("model_err",    32'(bus.err),         32'(m_err));
      chk("model_errcnt", 32'(bus.err_count),   32'(m_errcnt));
      chk("fv_err_excl",  32'(bus.frame_valid & bus.err), 32'd0);
    end
  end

  task automatic step(input logic [3:0] an, input logic [3:0] dig);
    bus.an_in    = an;
    bus.digit_in = dig;
    @(posedge kHzclk);
    #1;
  endtask

  task automatic run_frame(input logic [15:0] v);
    step(4'b1110, v[3:0]);
    step(4'b1101, v[7:4]);
    step(4'b1011, v[11:8]);
    step(4'b0111, v[15:12]);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(posedge kHzclk);
    #1 reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_value"},  32'(bus.value),       32'd0);
    chk({tag, "_fv"},     32'(bus.frame_valid), 32'd0);
    chk({tag, "_locked"}, 32'(bus.locked),      32'd0);
    chk({tag, "_err"},    32'(bus.err),         32'd0);
    chk({tag, "_errcnt"}, 32'(bus.err_count),   32'd0);
  endtask

  initial begin
    bus.an_in    = 4'b1111;
    bus.digit_in = 4'h0;
    repeat (2) @(posedge kHzclk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // 0xBEEF scanned repeatedly
    step(4'b1110, 4'hF);
    step(4'b1101, 4'hE);
    step(4'b1011, 4'hE);
    chk("beef_no_fv_early", 32'(bus.frame_valid), 32'd0);
    chk("beef_not_locked_early", 32'(bus.locked), 32'd0);
    step(4'b0111, 4'hB);
    chk("beef_value", 32'(bus.value), 32'h0000BEEF);
    chk("beef_fv", 32'(bus.frame_valid), 32'd1);
    chk("beef_locked", 32'(bus.locked), 32'd1);
    for (int f = 0; f < 2; f++) begin
      step(4'b1110, 4'hF);
      chk("beef_fv_drop", 32'(bus.frame_valid), 32'd0);
      step(4'b1101, 4'hE);
      step(4'b1011, 4'hE);
      step(4'b0111, 4'hB);
      chk("beef_fv_period", 32'(bus.frame_valid), 32'd1);
    end

    // mid-frame start: index 2 and 3 ignored while hunting
    do_reset();
    step(4'b1011, 4'h3);
    chk("hunt_no_err2", 32'(bus.err), 32'd0);
    step(4'b0111, 4'h4);
    chk("hunt_no_err3", 32'(bus.err), 32'd0);
    step(4'b1110, 4'h1);
    step(4'b1101, 4'h2);
    step(4'b1011, 4'h3);
    chk("mid_no_fv", 32'(bus.frame_valid), 32'd0);
    step(4'b0111, 4'h4);
    chk("mid_value", 32'(bus.value), 32'h00004321);
    chk("mid_fv", 32'(bus.frame_valid), 32'd1);

    // skipped index 2 while locked
    step(4'b1110, 4'h5);
    step(4'b1101, 4'h6);
    step(4'b0111, 4'h7);
    chk("skip_err", 32'(bus.err), 32'd1);
    chk("skip_unlock", 32'(bus.locked), 32'd0);
    chk("skip_value_hold", 32'(bus.value), 32'h00004321);
    step(4'b1011, 4'h8);
    chk("skip_hunt_quiet", 32'(bus.err), 32'd0);

    // illegal pattern and error saturation
    do_reset();
    run_frame(16'hBEEF);
    step(4'b1100, 4'h0);
    chk("illegal_err", 32'(bus.err), 32'd1);
    chk("illegal_unlock", 32'(bus.locked), 32'd0);
`ifdef SEG_RX_ERRCNT_EN
    chk("illegal_errcnt", 32'(bus.err_count), 32'd1);
`else
    chk("illegal_errcnt", 32'(bus.err_count), 32'd0);
`endif
    step(4'b1110, 4'h0);
    for (int i = 0; i < 300; i++) step(4'b1110, 4'h1);
`ifdef SEG_RX_ERRCNT_EN
    chk("errcnt_sat", 32'(bus.err_count), 32'd255);
`else
    chk("errcnt_sat", 32'(bus.err_count), 32'd0);
`endif

    // idle timeout and blank
    do_reset();
    run_frame(16'h1234);
    repeat (IDLE_MAX - 1) step(4'b1111, 4'h0);
    chk("idle_still_locked", 32'(bus.locked), 32'd1);
    step(4'b1111, 4'h0);
    chk("idle_unlock", 32'(bus.locked), 32'd0);
    chk("idle_no_err", 32'(bus.err), 32'd0);
    run_frame(16'h5678);
    chk("relock", 32'(bus.locked), 32'd1);
    step(4'b0000, 4'h0);
    chk("blank_unlock", 32'(bus.locked), 32'd0);
    chk("blank_no_err", 32'(bus.err), 32'd0);
    step(4'b0111, 4'h9);
    chk("blank_hunt_quiet", 32'(bus.err), 32'd0);

    // asynchronous reset between index 1 and index 2
    run_frame(16'hBEEF);
    step(4'b1110, 4'h1);
    step(4'b1101, 4'h2);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge kHzclk);
    #1 reset = 1'b0;
    step(4'b1011, 4'h3);
    step(4'b0111, 4'h4);
    chk("post_rst_no_fv", 32'(bus.frame_valid), 32'd0);
    step(4'b1110, 4'hA);
    step(4'b1101, 4'hB);
    step(4'b1011, 4'hC);
    chk("post_rst_no_fv2", 32'(bus.frame_valid), 32'd0);
    step(4'b0111, 4'hD);
    chk("post_rst_fv", 32'(bus.frame_valid), 32'd1);
    chk("post_rst_value", 32'(bus.value), 32'h0000DCBA);
    step(4'b1111, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
